fetch_buffer: RTL
=================

Name: fetch_buffer

Overview:
- Consumer end of the PC generator: takes each fetch address from the PC register and issues it to instruction memory over a req/ack handshake.
- Holds in-order responses in a DEPTH-entry ring, each entry paired with its PC.
- Presents instructions to decode on a valid/ready interface.
- Back-pressures the PC generator when full; discards buffered and in-flight fetches on a redirect flush.

Parameters:
DBITS, 32, data/address width
DEPTH, 4, ring entries and max outstanding fetches (power of 2, >=2)
PTRBITS, 2, log2(DEPTH)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-low; state cleared on rising clk while reset==0
pcIn  input  DBITS  fetch address from PC register
pcValid  input  1  pcIn is a fetch candidate
pcAdvance  output  1  fetch accepted this cycle; PC generator may update
flush  input  1  redirect: drop all entries and in-flight fetches
imemReq  output  1  request to instruction memory
imemAddr  output  DBITS  request address (= pcIn)
imemAck  input  1  memory accepted request this cycle
imemRspValid  input  1  response word valid (responses strictly in order)
imemRspData  input  DBITS  instruction word
instValid  output  1  head entry holds an instruction
instOut  output  DBITS  head instruction
instPc  output  DBITS  PC of head instruction
instReady  input  1  decode consumes head when instValid && instReady

Behaviour:
State:
- Pointers head, fill, tail, each PTRBITS+1 wide (wrap bit).
- occ = tail-head (0..DEPTH); pending = tail-fill.
- dropCnt, PTRBITS+1 bits.
- Per entry: pc and inst.

Reset (reset==0 at clk edge):
- head=fill=tail=0, dropCnt=0.
- While reset==0: imemReq=0, pcAdvance=0, instValid=0.
- Reset overrides flush and every handshake, including mid-transaction; the memory side must tolerate abandoned requests.

Issue:
- imemReq = reset && pcValid && !flush && (occ+dropCnt < DEPTH); imemAddr = pcIn.
- Accept = imemReq && imemAck. On accept: entry[tail].pc <= pcIn, tail++.
- pcAdvance = accept (combinational); PC must not advance without it.

Response:
- If imemRspValid && dropCnt!=0: dropCnt--, word discarded.
- Else if imemRspValid: entry[fill].inst <= imemRspData, fill++.
- imemRspValid with dropCnt==0 and pending==0 is a protocol error; ignore it; covered by assertion.

Output:
- instValid = (fill != head), registered state.
- instOut/instPc = entry[head].
- Latency: response at edge N -> instValid high after edge N (visible cycle N+1).
- Pop on instValid && instReady: head++.
- Fill and pop may both occur in the same cycle.
- instOut/instPc are held stable while instValid && !instReady.

Flush (flush==1, reset==1):
- Next state: head=fill=tail; dropCnt = dropCnt + pending.
- A response in the flush cycle is counted against the new dropCnt (net: dropCnt + pending - 1, not filled).
- No issue and no pop in the flush cycle; instValid=0 the next cycle.
- Issue resumes the cycle after flush, bounded by occ+dropCnt<DEPTH.

Boundaries:
- Full (occ+dropCnt==DEPTH): imemReq=0, pcAdvance=0.
- A pop and an issue in the same cycle when full: pop frees the slot for the next cycle only (no same-cycle bypass).
- Pointer wrap: low PTRBITS index the ring; full/empty are distinguished by the wrap bit.
- The invariant occ+dropCnt <= DEPTH must always hold (assertion).

Test Plan:
- Reset hold: reset=0 for 3 cycles with pcValid=1, imemRspValid=1 -> imemReq=0, instValid=0, pcAdvance=0 throughout.
- Streaming: pcIn=64,68,72 with imemAck=1; rsp 0xA,0xB,0xC one cycle later each; instReady=1 -> instValid for (64,0xA),(68,0xB),(72,0xC) on consecutive cycles, each one cycle after its response.
- Full stall: instReady=0, DEPTH=4, issue 64..76 with all responses -> 5th cycle imemReq=0, pcAdvance=0. Pop one -> next cycle imemReq=1 for pcIn=80.
- Ack stall: imemAck=0 for 2 cycles at pcIn=64 -> pcAdvance=0, imemAddr=64 held; accept on the 3rd cycle.
- Flush with in-flight: issue 64,68,72, fill 64 only, assert flush -> dropCnt=2, instValid=0. Next responses 0x1,0x2 are discarded. New fetch 200 with rsp 0x9 -> instValid (200,0x9) only.
- Wrap/simultaneous: run 10 fetches with instReady toggling 1,0; fill and pop coincide -> output order and PCs exact, no loss or duplication across pointer wrap.

Source files
------------

// File: rtl/fetch_buffer.sv
// Fetch buffer: issues PC-register addresses to instruction memory and queues the
// in-order responses with their PCs for decode, dropping stale fetches on redirect.
module fetch_buffer #(
    parameter int DBITS   = 32,
    parameter int DEPTH   = 4,
    parameter int PTRBITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] pcIn,
    input  logic             pcValid,
    output logic             pcAdvance,
    input  logic             flush,
    output logic             imemReq,
    output logic [DBITS-1:0] imemAddr,
    input  logic             imemAck,
    input  logic             imemRspValid,
    input  logic [DBITS-1:0] imemRspData,
    output logic             instValid,
    output logic [DBITS-1:0] instOut,
    output logic [DBITS-1:0] instPc,
    input  logic             instReady
);

    localparam int PW = PTRBITS + 1;
    typedef logic [PW-1:0] ptr_t;
    localparam logic [PW:0] DEPTH_W = (PW + 1)'(DEPTH);
    localparam ptr_t        ONE     = ptr_t'(1);

    ptr_t head_q, head_d;
    ptr_t fill_q, fill_d;
    ptr_t tail_q, tail_d;
    ptr_t drop_q, drop_d;

    logic [DBITS-1:0] pc_q   [DEPTH];
    logic [DBITS-1:0] inst_q [DEPTH];

    ptr_t          occ;
    ptr_t          pending;
    logic [PW:0]   budget;
    logic          accept;
    logic          pop;
    logic          rsp_fill;
    logic [PTRBITS-1:0] head_idx;
    logic [PTRBITS-1:0] fill_idx;
    logic [PTRBITS-1:0] tail_idx;

    assign occ      = tail_q - head_q;
    assign pending  = tail_q - fill_q;
    assign budget   = {1'b0, occ} + {1'b0, drop_q};
    assign head_idx = head_q[PTRBITS-1:0];
    assign fill_idx = fill_q[PTRBITS-1:0];
    assign tail_idx = tail_q[PTRBITS-1:0];

    // Issue side: dropped-but-outstanding fetches still hold a memory slot.
    assign imemReq   = reset && pcValid && !flush && (budget < DEPTH_W);
    assign imemAddr  = pcIn;
    assign accept    = imemReq && imemAck;
    assign pcAdvance = accept;

    assign instValid = reset && (fill_q != head_q);
    assign pop       = instValid && instReady && !flush;
    assign instOut   = inst_q[head_idx];
    assign instPc    = pc_q[head_idx];

    always_comb begin
        drop_d   = drop_q;
        rsp_fill = 1'b0;
        if (flush) begin
            // A response arriving during the flush belongs to the old stream.
            drop_d = drop_q + pending;
            if (imemRspValid && (drop_d != '0)) begin
                drop_d = drop_d - ONE;
            end
        end else if (imemRspValid) begin
            if (drop_q != '0) begin
                drop_d = drop_q - ONE;
            end else if (pending != '0) begin
                rsp_fill = 1'b1;
            end
        end
    end

    always_comb begin
        head_d = head_q;
        fill_d = fill_q;
        tail_d = tail_q;
        if (flush) begin
            head_d = tail_q;
            fill_d = tail_q;
        end else begin
            if (accept)   tail_d = tail_q + ONE;
            if (rsp_fill) fill_d = fill_q + ONE;
            if (pop)      head_d = head_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q <= '0;
            fill_q <= '0;
            tail_q <= '0;
            drop_q <= '0;
        end else begin
            head_q <= head_d;
            fill_q <= fill_d;
            tail_q <= tail_d;
            drop_q <= drop_d;
        end
    end

    // Entry storage carries no reset; validity lives entirely in the pointers.
    always_ff @(posedge clk) begin
        if (accept) begin
            pc_q[tail_idx] <= pcIn;
        end
        if (reset && rsp_fill) begin
            inst_q[fill_idx] <= imemRspData;
        end
    end

    a_budget : assert property (@(posedge clk) disable iff (!reset) budget <= DEPTH_W);
    a_rsp_expected : assert property (@(posedge clk) disable iff (!reset)
        imemRspValid |-> ((drop_q != '0) || (pending != '0)));

endmodule
